// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the UART command parser.
// Holds the frame delimiters, frame length, axis bit positions and legal
// axis mask, the error codes reported on err_code_o, the parser FSM state
// encoding and the axis legality check used by the tail decision.
package uart_cmd_parser_pkg;

  localparam logic [7:0] FRAME_HEADER = 8'h55;
  localparam logic [7:0] FRAME_TAIL   = 8'hAA;

  // header + code + axis + speed + 4 position bytes + tail
  localparam int unsigned FRAME_LEN = 9;
  // Index of the last body byte (position LSB); body indices run 0..6.
  localparam logic [2:0]  BODY_LAST_IDX = 3'(FRAME_LEN - 3);

  localparam int unsigned AXIS_X_BIT = 0;
  localparam int unsigned AXIS_Y_BIT = 1;
  localparam int unsigned AXIS_Z_BIT = 2;
  localparam int unsigned AXIS_W_BIT = 3;
  localparam logic [7:0]  AXIS_LEGAL_MASK = 8'((1 << AXIS_X_BIT) | (1 << AXIS_Y_BIT) |
                                               (1 << AXIS_Z_BIT) | (1 << AXIS_W_BIT));

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_TAIL     = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_AXIS_OVR = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BODY = 2'd1,
    ST_TAIL = 2'd2
  } state_e;

  // Legal axis: nonzero, one-hot, and no bits outside the mask.
  function automatic logic axis_legal(input logic [7:0] axis, input logic [7:0] mask);
    return (axis != 8'h00) && ((axis & (axis - 8'h01)) == 8'h00) && ((axis & ~mask) == 8'h00);
  endfunction

endpackage

// File: rtl/uart_cmd_parser_timeout.sv
// Inter-byte timeout counter for the UART command parser.
// Ports:
//   clk_i     system clock
//   rst_ni    asynchronous active-low reset
//   clear_i   restart the count (byte received or parser idle)
//   enable_i  count this cycle (frame partially received)
//   expire_o  single-cycle pulse when the count reaches TIMEOUT_CYCLES-1
//             in a cycle that is counting and not being cleared
module uart_cmd_parser_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 400_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int unsigned      CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             expire_s;

  // A clear in the terminal cycle suppresses expiry: a late byte still counts.
  assign expire_s = enable_i & ~clear_i & (cnt_q == CNT_MAX);
  assign expire_o = expire_s;

  // Next count: restart on clear or expiry, otherwise advance while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || expire_s) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// UART command parser: frames 9-byte packets (header, code, axis, speed,
// 4-byte big-endian position, tail) from the receiver byte stream and
// presents one decoded command per good frame on a valid/ready interface.
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   rx_data_i/rx_valid_i  received byte and its one-cycle strobe
//   cmd_valid_o           decoded command pending (held until cmd_ready_i)
//   cmd_ready_i           downstream accepts when cmd_valid_o & cmd_ready_i
//   cmd_code_o/axis/speed command fields (frame bytes 1..3)
//   cmd_position_o        frame bytes 4..7, byte 4 in [31:24]
//   frame_err_o           one-cycle error pulse
//   err_code_o            1 bad tail, 2 timeout, 3 bad axis/overrun; holds last
//   busy_o                a frame is partially received
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter logic [7:0]  HEADER_BYTE    = FRAME_HEADER,
  parameter logic [7:0]  TAIL_BYTE      = FRAME_TAIL,
  parameter logic [7:0]  AXIS_MASK      = AXIS_LEGAL_MASK,
  parameter int unsigned TIMEOUT_CYCLES = 400_000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  output logic [7:0]  cmd_code_o,
  output logic [7:0]  cmd_axis_o,
  output logic [7:0]  cmd_speed_o,
  output logic [31:0] cmd_position_o,
  output logic        frame_err_o,
  output logic [1:0]  err_code_o,
  output logic        busy_o
);

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;

  // Frame under assembly.
  logic [7:0]  frm_code_q, frm_code_d;
  logic [7:0]  frm_axis_q, frm_axis_d;
  logic [7:0]  frm_speed_q, frm_speed_d;
  logic [31:0] frm_pos_q, frm_pos_d;

  // Command presented downstream.
  logic        cmd_valid_q, cmd_valid_d;
  logic [7:0]  cmd_code_q, cmd_code_d;
  logic [7:0]  cmd_axis_q, cmd_axis_d;
  logic [7:0]  cmd_speed_q, cmd_speed_d;
  logic [31:0] cmd_pos_q, cmd_pos_d;

  logic        frame_err_q, frame_err_d;
  logic [1:0]  err_code_q, err_code_d;

  logic        to_clear_s;
  logic        to_enable_s;
  logic        to_expire_s;

  assign to_clear_s  = rx_valid_i | (state_q == ST_IDLE);
  assign to_enable_s = (state_q != ST_IDLE);

  uart_cmd_parser_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (to_clear_s),
    .enable_i(to_enable_s),
    .expire_o(to_expire_s)
  );

  // Framing FSM, frame assembly, command handoff and error reporting.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    frm_code_d  = frm_code_q;
    frm_axis_d  = frm_axis_q;
    frm_speed_d = frm_speed_q;
    frm_pos_d   = frm_pos_q;
    // Handshake retires the pending command unless a completion reloads it.
    cmd_valid_d = cmd_valid_q & ~cmd_ready_i;
    cmd_code_d  = cmd_code_q;
    cmd_axis_d  = cmd_axis_q;
    cmd_speed_d = cmd_speed_q;
    cmd_pos_d   = cmd_pos_q;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid_i && (rx_data_i == HEADER_BYTE)) begin
          state_d = ST_BODY;
          idx_d   = 3'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_BODY: begin
        if (rx_valid_i) begin
          // The header value is ordinary data here; no resynchronisation.
          case (idx_q)
            3'd0:    frm_code_d  = rx_data_i;
            3'd1:    frm_axis_d  = rx_data_i;
            3'd2:    frm_speed_d = rx_data_i;
            default: frm_pos_d   = {frm_pos_q[23:0], rx_data_i};
          endcase
          idx_d = idx_q + 3'd1;
          if (idx_q == BODY_LAST_IDX) begin
            state_d = ST_TAIL;
          end else begin
            state_d = ST_BODY;
          end
        end else if (to_expire_s) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
        end else begin
          state_d = ST_BODY;
        end
      end

      ST_TAIL: begin
        if (rx_valid_i) begin
          state_d = ST_IDLE;
          if (rx_data_i != TAIL_BYTE) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_TAIL;
          end else if (!axis_legal(frm_axis_q, AXIS_MASK)) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_AXIS_OVR;
          end else if (!cmd_valid_q || cmd_ready_i) begin
            cmd_valid_d = 1'b1;
            cmd_code_d  = frm_code_q;
            cmd_axis_d  = frm_axis_q;
            cmd_speed_d = frm_speed_q;
            cmd_pos_d   = frm_pos_q;
          end else begin
            // Previous command still unaccepted: drop this one (overrun).
            frame_err_d = 1'b1;
            err_code_d  = ERR_AXIS_OVR;
          end
        end else if (to_expire_s) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
        end else begin
          state_d = ST_TAIL;
        end
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = 3'd0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      idx_q       <= 3'd0;
      frm_code_q  <= 8'h00;
      frm_axis_q  <= 8'h00;
      frm_speed_q <= 8'h00;
      frm_pos_q   <= 32'h0000_0000;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= 8'h00;
      cmd_axis_q  <= 8'h00;
      cmd_speed_q <= 8'h00;
      cmd_pos_q   <= 32'h0000_0000;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      frm_code_q  <= frm_code_d;
      frm_axis_q  <= frm_axis_d;
      frm_speed_q <= frm_speed_d;
      frm_pos_q   <= frm_pos_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      cmd_axis_q  <= cmd_axis_d;
      cmd_speed_q <= cmd_speed_d;
      cmd_pos_q   <= cmd_pos_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign cmd_valid_o    = cmd_valid_q;
  assign cmd_code_o     = cmd_code_q;
  assign cmd_axis_o     = cmd_axis_q;
  assign cmd_speed_o    = cmd_speed_q;
  assign cmd_position_o = cmd_pos_q;
  assign frame_err_o    = frame_err_q;
  assign err_code_o     = err_code_q;
  assign busy_o         = (state_q != ST_IDLE);

endmodule
